// File: rtl/cdc_afifo_rd_stream.sv
// cdc_afifo_rd_stream
// Read-side consumer for the async CDC FIFO (show-ahead). It turns the FIFO
// rd/rempty/rdata port into a valid/ready stream through a 2-entry skid buffer.
// The pop strobe depends only on registered occupancy, never on i_ready.
// A flush drains and discards everything pending, then pulses o_flush_done.
// Optional feature: define CDC_AFIFO_RD_STAT_EN to enable the delivered-beat
// counter on o_rd_cnt. Without it, o_rd_cnt is tied to zero.
module cdc_afifo_rd_stream #(
  parameter int dbits   = 32,
  parameter int cntbits = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_fifo_rd,
  input  logic [dbits-1:0]   i_fifo_rdata,
  input  logic               i_fifo_rempty,
  output logic               o_valid,
  output logic [dbits-1:0]   o_data,
  input  logic               i_ready,
  input  logic               i_flush,
  output logic               o_flush_done,
  output logic [cntbits-1:0] o_rd_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       cnt_reg, cnt_next;
  logic [1:0]       cnt_after_deq;
  logic [dbits-1:0] buf_reg  [0:1];
  logic [dbits-1:0] buf_next [0:1];
  logic             flush_done_reg, flush_done_next;
  logic             fifo_rd;
  logic             deq;

  // Next-state logic: dequeue shift first, then the popped word lands in
  // the first free slot; a flush request overrides the occupancy.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    cnt_after_deq   = cnt_reg;
    buf_next[0]     = buf_reg[0];
    buf_next[1]     = buf_reg[1];
    flush_done_next = 1'b0;
    fifo_rd         = 1'b0;
    deq             = 1'b0;
    case (state_reg)
      RUN: begin
        fifo_rd = ~i_fifo_rempty & (cnt_reg != 2'd2);
        deq     = (cnt_reg != 2'd0) & i_ready;
        if (deq) begin
          buf_next[0]   = buf_reg[1];
          cnt_after_deq = cnt_reg - 2'd1;
        end
        if (fifo_rd) begin
          if (cnt_after_deq == 2'd0) begin
            buf_next[0] = i_fifo_rdata;
          end else begin
            buf_next[1] = i_fifo_rdata;
          end
        end
        cnt_next = cnt_after_deq + {1'b0, fifo_rd};
        // The handshake above still completes; buffered words are dropped.
        if (i_flush) begin
          cnt_next   = 2'd0;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        // Pop and discard until the FIFO reports empty.
        fifo_rd = ~i_fifo_rempty;
        if (i_fifo_rempty) begin
          state_next      = RUN;
          flush_done_next = 1'b1;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State, occupancy, buffer slots and the flush-done pulse register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= RUN;
      cnt_reg        <= 2'd0;
      flush_done_reg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_reg[i] <= '0;
      end
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      flush_done_reg <= flush_done_next;
      for (int i = 0; i < 2; i++) begin
        buf_reg[i] <= buf_next[i];
      end
    end
  end

  // Gate the pop strobe with reset so the FIFO is never popped while held.
  assign o_fifo_rd    = fifo_rd & ~i_rst;
  assign o_valid      = (cnt_reg != 2'd0) && (state_reg == RUN);
  assign o_data       = buf_reg[0];
  assign o_flush_done = flush_done_reg;

`ifdef CDC_AFIFO_RD_STAT_EN
  logic [cntbits-1:0] rd_cnt_reg;

  // Delivered-beat counter; wraps naturally, flushed words never handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_cnt_reg <= '0;
    end else if (deq) begin
      rd_cnt_reg <= rd_cnt_reg + cntbits'(1);
    end
  end

  assign o_rd_cnt = rd_cnt_reg;
`else
  assign o_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_cdc_afifo_rd_stream.sv
// Testbench for cdc_afifo_rd_stream: a queue models the FIFO contents and a
// second queue models the words held for delivery (at most two).
module tb_cdc_afifo_rd_stream;
  localparam int DB   = 32;
  localparam int CNTB = 8;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            o_fifo_rd;
  logic [DB-1:0]   i_fifo_rdata;
  logic            i_fifo_rempty;
  logic            o_valid;
  logic [DB-1:0]   o_data;
  logic            i_ready;
  logic            i_flush;
  logic            o_flush_done;
  logic [CNTB-1:0] o_rd_cnt;

  cdc_afifo_rd_stream #(.dbits(DB), .cntbits(CNTB)) dut (
    .i_clk(clk), .i_rst(i_rst), .o_fifo_rd(o_fifo_rd),
    .i_fifo_rdata(i_fifo_rdata), .i_fifo_rempty(i_fifo_rempty),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .i_flush(i_flush), .o_flush_done(o_flush_done), .o_rd_cnt(o_rd_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DB-1:0] fifo_q[$];
  logic [DB-1:0] mbuf[$];
  bit            m_run  = 1'b1;
  bit            m_done = 1'b0;
  int            m_cnt  = 0;
  int            pops_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt();
`ifdef CDC_AFIFO_RD_STAT_EN
    return 64'(m_cnt % (1 << CNTB));
`else
    return 64'd0;
`endif
  endfunction

  // Called at a falling edge: drive inputs, check outputs, advance the model,
  // then wait for the next falling edge.
  task automatic cycle(input bit rdy, input bit fl);
    bit e, exp_rd, exp_v;
    logic [DB-1:0] w;
    i_ready = rdy;
    i_flush = fl;
    e = (fifo_q.size() == 0);
    i_fifo_rempty = e;
    i_fifo_rdata  = e ? 32'hDEAD_BEEF : fifo_q[0];
    #1;
    exp_v  = m_run && (mbuf.size() != 0);
    exp_rd = !e && (!m_run || mbuf.size() < 2);
    chk("fifo_rd", 64'(o_fifo_rd), 64'(exp_rd));
    chk("valid", 64'(o_valid), 64'(exp_v));
    if (exp_v) chk("data", 64'(o_data), 64'(mbuf[0]));
    chk("flush_done", 64'(o_flush_done), 64'(m_done));
    chk("rd_cnt", 64'(o_rd_cnt), exp_cnt());
    if (exp_rd) pops_seen++;
    if (exp_v && rdy) begin
      void'(mbuf.pop_front());
      m_cnt++;
    end
    if (exp_rd) begin
      w = fifo_q.pop_front();
      if (m_run && !fl) mbuf.push_back(w);
    end
    if (m_run) begin
      m_done = 1'b0;
      if (fl) begin
        mbuf.delete();
        m_run = 1'b0;
      end
    end else begin
      m_done = e;
      if (e) m_run = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_fifo_rd", 64'(o_fifo_rd), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_flush_done", 64'(o_flush_done), 64'd0);
    chk("rst_rd_cnt", 64'(o_rd_cnt), 64'd0);
  endtask

  initial begin
    int cnt_before;
    i_rst = 1'b1; i_ready = 1'b1; i_flush = 1'b0;
    fifo_q = '{32'h11, 32'h22, 32'h33};
    i_fifo_rempty = 1'b0; i_fifo_rdata = 32'h11;

    // Reset held with a non-empty FIFO: nothing may move.
    repeat (3) begin
      @(negedge clk);
      #1 check_reset_outputs();
    end
    @(negedge clk);
    i_rst = 1'b0;

    // Streaming three words with the sink always ready.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);

    // Backpressure: four words, sink stalled, then released.
    fifo_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    pops_seen = 0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
    chk("bp_pops", 64'(pops_seen), 64'd2);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);

    // Steady state: one pop and one delivery per cycle.
    fifo_q.push_back(32'h100);
    for (int i = 0; i < 12; i++) begin
      fifo_q.push_back(32'h200 + i);
      cycle(1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);

    // Flush with two buffered words and three more in the FIFO.
    fifo_q = '{32'hB1, 32'hB2};
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    fifo_q.push_back(32'hC1); fifo_q.push_back(32'hC2); fifo_q.push_back(32'hC3);
    cnt_before = m_cnt;
    pops_seen = 0;
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
    chk("flush_pops", 64'(pops_seen), 64'd3);
    chk("flush_cnt_same", 64'(m_cnt), 64'(cnt_before));

    // Flush while already empty completes in a single cycle.
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);

    // Counter wrap: 2^CNTB + 1 beats delivered back to back.
    cnt_before = m_cnt;
    fifo_q.push_back(32'h5000);
    while (m_cnt - cnt_before < (1 << CNTB) + 1) begin
      fifo_q.push_back(32'h5001 + m_cnt);
      cycle(1'b1, 1'b0);
    end
    fifo_q.delete();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    chk("cnt_final", 64'(o_rd_cnt), exp_cnt());

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 3 != 0) && fifo_q.size() < 6) fifo_q.push_back($urandom);
      cycle(($urandom % 4) != 0, ($urandom % 32) == 0);
    end

    // Reset mid-operation (FIFO reset together with the block).
    fifo_q.push_back(32'hE1); fifo_q.push_back(32'hE2);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0);
    i_rst = 1'b1;
    #1 check_reset_outputs();
    fifo_q.delete(); mbuf.delete();
    m_run = 1'b1; m_done = 1'b0; m_cnt = 0;
    @(negedge clk);
    i_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (($urandom % 2) != 0 && fifo_q.size() < 6) fifo_q.push_back($urandom);
      cycle(($urandom % 3) != 0, ($urandom % 40) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
